// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester (cpu, dbg) and memory-side signals of the data memory arbiter
interface dmem_arbiter_if #(
    parameter int ADR_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int CNT_WIDTH  = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADR_WIDTH-1:0]  cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_stall;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_err;
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADR_WIDTH-1:0]  dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_err;
    logic                  mem_read;
    logic                  mem_write;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    // arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output stall_cnt
    );

    // requester/memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  stall_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between cpu and dbg with cpu priority and a dbg starvation guard
module dmem_arbiter #(
    parameter int ADR_WIDTH    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 6,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic                  dbg_win, cpu_win, win, we, ok, stall, cpu_done, dbg_done;
    logic [ADR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         starve_d, starve_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_d, stall_cnt_q;
    logic                  cpu_rvalid_d, cpu_rvalid_q, cpu_err_d, cpu_err_q;
    logic                  dbg_rvalid_d, dbg_rvalid_q, dbg_err_d, dbg_err_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_d, cpu_rdata_q, dbg_rdata_d, dbg_rdata_q;

    // arbitration, address check, memory command and next-state of all registers
    always_comb begin
        dbg_win  = bus.dbg_req && (!bus.cpu_req || starve_q == LIMIT);
        cpu_win  = bus.cpu_req && !dbg_win;
        win      = dbg_win || cpu_win;
        addr     = dbg_win ? bus.dbg_addr : bus.cpu_addr;
        we       = dbg_win ? bus.dbg_we : bus.cpu_we;
        wdata    = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
        ok       = addr[1:0] == 2'b00 && (addr >> (DEPTH_LOG2 + 2)) == '0;
        stall    = bus.cpu_req && !cpu_win;
        // a granted access produces a response unless it is a good write
        cpu_done = cpu_win && (!ok || !we);
        dbg_done = dbg_win && (!ok || !we);
        cpu_rvalid_d = cpu_done;
        cpu_err_d    = cpu_done ? !ok : cpu_err_q;
        cpu_rdata_d  = cpu_done ? (ok ? bus.mem_rdata : '0) : cpu_rdata_q;
        dbg_rvalid_d = dbg_done;
        dbg_err_d    = dbg_done ? !ok : dbg_err_q;
        dbg_rdata_d  = dbg_done ? (ok ? bus.mem_rdata : '0) : dbg_rdata_q;
        starve_d     = (bus.dbg_req && !dbg_win) ? (starve_q == LIMIT ? LIMIT : starve_q + 1'b1) : '0;
        stall_cnt_d  = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // state registers; reset drops any in-flight read response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q     <= '0;
            stall_cnt_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            stall_cnt_q  <= stall_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_err_q    <= dbg_err_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign bus.cpu_stall  = stall;
    assign bus.dbg_gnt    = dbg_win;
    assign bus.mem_read   = win && ok && !we;
    assign bus.mem_write  = win && ok && we;
    assign bus.mem_addr   = win ? addr[DEPTH_LOG2+1:2] : '0;
    assign bus.mem_wdata  = win ? wdata : '0;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_err    = dbg_err_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against dmem_arbiter with a behavioural 64-word memory
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic        bd_we = 1'b0;
    logic [5:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    logic [31:0] mem [64];

    dmem_arbiter_if #(.ADR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(6), .CNT_WIDTH(16)) bus ();

    dmem_arbiter #(.ADR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(6), .STARVE_LIMIT(4), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // memory model: combinational read, write on rising edge, plus a backdoor preload
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    endtask

    task automatic cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic dbg(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    endtask

    initial begin
        idle();
        // preload word 4 while in reset
        bd_we = 1; bd_addr = 6'd4; bd_data = 32'hDEADBEEF;
        tick();
        bd_we = 0;
        tick();
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        rst = 1;

        // cpu read of word 4
        cpu(0, 32'h10, 0); #1;
        check("rd_mem_read", 32'(bus.mem_read), 1);
        check("rd_mem_addr", 32'(bus.mem_addr), 4);
        check("rd_stall", 32'(bus.cpu_stall), 0);
        tick(); idle();
        check("rd_rvalid", 32'(bus.cpu_rvalid), 1);
        check("rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        tick();
        check("rd_rvalid_pulse", 32'(bus.cpu_rvalid), 0);
        check("rd_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

        // cpu write then read of 0x20
        cpu(1, 32'h20, 32'h12345678); #1;
        check("wr_mem_write", 32'(bus.mem_write), 1);
        check("wr_mem_addr", 32'(bus.mem_addr), 8);
        check("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
        tick();
        check("wr_no_rvalid", 32'(bus.cpu_rvalid), 0);
        cpu(0, 32'h20, 0);
        tick(); idle();
        check("wr_rb_rvalid", 32'(bus.cpu_rvalid), 1);
        check("wr_rb_rdata", bus.cpu_rdata, 32'h12345678);

        // contention: dbg starved for 4 cycles, forced grant in the 5th
        cpu(0, 32'h10, 0); dbg(0, 32'h20, 0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("starve%0d_gnt", k), 32'(bus.dbg_gnt), 0);
            check($sformatf("starve%0d_stall", k), 32'(bus.cpu_stall), 0);
            tick();
        end
        #1;
        check("forced_gnt", 32'(bus.dbg_gnt), 1);
        check("forced_stall", 32'(bus.cpu_stall), 1);
        check("forced_mem_addr", 32'(bus.mem_addr), 8);
        tick();
        bus.dbg_req = 0;
        check("forced_stall_cnt", 32'(bus.stall_cnt), 1);
        check("forced_dbg_rvalid", 32'(bus.dbg_rvalid), 1);
        check("forced_dbg_rdata", bus.dbg_rdata, 32'h12345678);
        check("forced_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        #1;
        check("after_cpu_gnt", 32'(bus.cpu_stall), 0);
        tick(); idle();
        check("after_cpu_rvalid", 32'(bus.cpu_rvalid), 1);

        // bad addresses
        cpu(0, 32'h102, 0); #1;
        check("mis_mem_read", 32'(bus.mem_read), 0);
        tick(); idle();
        check("mis_rvalid", 32'(bus.cpu_rvalid), 1);
        check("mis_err", 32'(bus.cpu_err), 1);
        check("mis_rdata", bus.cpu_rdata, 0);
        cpu(0, 32'h100, 0); #1;
        check("oor_mem_read", 32'(bus.mem_read), 0);
        tick(); idle();
        check("oor_err", 32'(bus.cpu_err), 1);
        check("oor_rdata", bus.cpu_rdata, 0);
        cpu(1, 32'h100, 32'h55); #1;
        check("oor_wr_mem_write", 32'(bus.mem_write), 0);
        tick(); idle();
        check("oor_wr_rvalid", 32'(bus.cpu_rvalid), 1);
        check("oor_wr_err", 32'(bus.cpu_err), 1);
        cpu(0, 32'h10, 0);
        tick(); idle();
        check("clr_err", 32'(bus.cpu_err), 0);
        check("clr_rdata", bus.cpu_rdata, 32'hDEADBEEF);

        // dbg-only write to the last word, then cpu read back
        dbg(1, 32'hFC, 32'hA5A5A5A5); #1;
        check("dbgwr_gnt", 32'(bus.dbg_gnt), 1);
        check("dbgwr_mem_addr", 32'(bus.mem_addr), 63);
        check("dbgwr_mem_write", 32'(bus.mem_write), 1);
        tick(); idle();
        check("dbgwr_no_rvalid", 32'(bus.dbg_rvalid), 0);
        cpu(0, 32'hFC, 0);
        tick(); idle();
        check("dbgwr_rb", bus.cpu_rdata, 32'hA5A5A5A5);

        // async reset between a read grant and the next edge
        tick();
        cpu(0, 32'h10, 0);
        #2;
        rst = 0; idle();
        #1;
        check("arst_rvalid", 32'(bus.cpu_rvalid), 0);
        check("arst_rdata", bus.cpu_rdata, 0);
        check("arst_stall_cnt", 32'(bus.stall_cnt), 0);
        check("arst_err", 32'(bus.cpu_err), 0);
        tick();
        check("arst_rvalid_edge", 32'(bus.cpu_rvalid), 0);
        rst = 1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
